// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared word, queue entry and fetch FSM state types
package ifetch_queue_pkg;
  typedef logic [15:0] lc3b_word;
  typedef struct packed {lc3b_word pc; lc3b_word instr;} iq_entry_t;
  typedef enum logic [1:0] {IF_IDLE, IF_FETCH, IF_DISCARD} ifetch_state_t;
endpackage

// File: rtl/ifetch_queue_instr_queue.sv
// instr_queue: in-order circular FIFO of fetched instructions with synchronous clear
module instr_queue import ifetch_queue_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      enq_i,
  input  logic      deq_i,
  input  logic      clear_i,
  input  iq_entry_t data_i,
  output logic      full_o,
  output logic      empty_o,
  output iq_entry_t head_o
);
  localparam int PW = $clog2(DEPTH);
  iq_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [PW:0]     count_q;
  logic            do_deq;
  assign full_o  = count_q == (PW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_deq  = deq_i && !empty_o;
  assign head_o  = mem_q[head_q];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(do_deq);
      tail_q  <= tail_q + PW'(enq_i);
      count_q <= count_q + (PW+1)'(enq_i) - (PW+1)'(do_deq);
    end
  always_ff @(posedge clk)
    if (enq_i && !clear_i) mem_q[tail_q] <= data_i;
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC and I-cache request FSM feeding an in-order instruction queue
module ifetch_queue import ifetch_queue_pkg::*; #(
  parameter int       DEPTH    = 8,
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset,
  output logic     icache_read,
  output lc3b_word icache_address,
  input  logic     icache_resp,
  input  lc3b_word icache_rdata,
  input  logic     flush,
  input  lc3b_word flush_pc,
  input  logic     iq_dequeue,
  output logic     iq_empty,
  output lc3b_word iq_instr,
  output lc3b_word iq_pc
);
  ifetch_state_t state_q, state_d;
  lc3b_word      pc_q, pc_d, addr_q, addr_d;
  logic          full, enq;
  iq_entry_t     head;
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    addr_d         = addr_q;
    icache_read    = 1'b0;
    icache_address = pc_q;
    enq            = 1'b0;
    case (state_q)
      IF_IDLE: begin
        state_d = IF_FETCH;
        pc_d    = flush ? flush_pc : pc_q;
      end
      IF_FETCH: begin
        icache_read = !full;
        enq         = icache_read && icache_resp && !flush;
        pc_d        = flush ? flush_pc : enq ? pc_q + 16'd2 : pc_q;
        // an unanswered read must be allowed to complete at its original address
        if (flush && icache_read && !icache_resp) begin
          state_d = IF_DISCARD;
          addr_d  = pc_q;
        end
      end
      IF_DISCARD: begin
        icache_read    = 1'b1;
        icache_address = addr_q;
        pc_d           = flush ? flush_pc : pc_q;
        state_d        = icache_resp ? IF_FETCH : IF_DISCARD;
      end
      default: state_d = IF_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  instr_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_i   (enq),
    .deq_i   (iq_dequeue),
    .clear_i (flush),
    .data_i  ('{pc: pc_q, instr: icache_rdata}),
    .full_o  (full),
    .empty_o (iq_empty),
    .head_o  (head)
  );
  assign iq_instr = iq_empty ? 16'h0 : head.instr;
  assign iq_pc    = iq_empty ? 16'h0 : head.pc;
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: random and directed fetch traffic against a transaction-level queue model
module tb_ifetch_queue;
  localparam int DEPTH = 8;
  logic        clk = 0, reset = 1;
  logic        icache_read, icache_resp = 0, flush = 0, iq_dequeue = 0, iq_empty;
  logic [15:0] icache_address, icache_rdata = 0, flush_pc = 0, iq_instr, iq_pc;
  int          n_chk = 0, n_err = 0;
  logic        d_flush = 0, d_deq = 0;
  logic [15:0] d_fpc = 0;
  int          fixed_lat = 0, cache_lat = 0, cache_cnt = 0;
  logic [31:0] q [$];
  logic [15:0] m_pc, m_stale;
  logic        m_disc, m_started;
  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .icache_read(icache_read), .icache_address(icache_address),
    .icache_resp(icache_resp), .icache_rdata(icache_rdata), .flush(flush), .flush_pc(flush_pc),
    .iq_dequeue(iq_dequeue), .iq_empty(iq_empty), .iq_instr(iq_instr), .iq_pc(iq_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] mem_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_pc = 16'h0000;
    m_stale = 16'h0000;
    m_disc = 0;
    m_started = 0;
    cache_cnt = 0;
  endtask
  task automatic cycle();
    logic        exp_read;
    logic [15:0] exp_addr;
    @(negedge clk);
    if (icache_read && cache_cnt == 0)
      cache_lat = fixed_lat >= 0 ? fixed_lat : ($urandom_range(1) == 1 ? 0 : int'($urandom_range(6, 1)));
    icache_resp  = icache_read && cache_cnt >= cache_lat;
    icache_rdata = icache_resp ? mem_of(icache_address) : 16'hDEAD;
    flush        = d_flush;
    flush_pc     = d_fpc;
    iq_dequeue   = d_deq;
    #1;
    exp_read = !m_started ? 1'b0 : m_disc ? 1'b1 : q.size() < DEPTH;
    exp_addr = m_disc ? m_stale : m_pc;
    check("read", icache_read, exp_read);
    check("addr", icache_address, exp_addr);
    check("empty", iq_empty, q.size() == 0);
    check("iq_pc", iq_pc, q.size() > 0 ? q[0][31:16] : 16'h0);
    check("iq_instr", iq_instr, q.size() > 0 ? q[0][15:0] : 16'h0);
    if (flush) q.delete();
    else if (iq_dequeue && q.size() > 0) void'(q.pop_front());
    if (!m_started) begin
      m_started = 1;
      if (flush) m_pc = flush_pc;
    end else if (m_disc) begin
      if (icache_resp) m_disc = 0;
      if (flush) m_pc = flush_pc;
    end else if (flush) begin
      if (exp_read && !icache_resp) begin
        m_disc = 1;
        m_stale = m_pc;
      end
      m_pc = flush_pc;
    end else if (exp_read && icache_resp) begin
      q.push_back({m_pc, mem_of(m_pc)});
      m_pc = m_pc + 16'd2;
    end
    cache_cnt = !icache_read || icache_resp ? 0 : cache_cnt + 1;
  endtask
  task automatic settle();
    @(posedge clk);
    #1;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", icache_read, 0);
    check("rst_empty", iq_empty, 1);
    check("rst_addr", icache_address, 16'h0000);
    check("rst_pc", iq_pc, 16'h0);
    check("rst_instr", iq_instr, 16'h0);
    reset = 0;
    fixed_lat = 0;
    repeat (9) cycle();
    settle();
    check("t1_full_read", icache_read, 0);
    check("t1_head_pc", iq_pc, 16'h0000);
    check("t1_head_instr", iq_instr, mem_of(16'h0000));
    d_deq = 1;
    cycle();
    d_deq = 0;
    settle();
    check("t2_read", icache_read, 1);
    check("t2_addr", icache_address, 16'h0010);
    check("t2_head_pc", iq_pc, 16'h0002);
    d_flush = 1; d_fpc = 16'h0100;
    cycle();
    d_flush = 0; d_deq = 1;
    repeat (12) cycle();
    d_flush = 1; d_fpc = 16'h0000;
    cycle();
    d_flush = 0;
    for (int i = 0; i < 20 && m_pc != 16'h0006; i++) cycle();
    fixed_lat = 9;
    cycle();
    cycle();
    d_flush = 1; d_fpc = 16'h3000;
    cycle();
    d_flush = 0; fixed_lat = 0;
    settle();
    check("t4_stale_addr", icache_address, 16'h0006);
    for (int i = 0; i < 20 && m_disc; i++) cycle();
    settle();
    check("t4_empty", iq_empty, 1);
    check("t4_next_addr", icache_address, 16'h3000);
    cycle();
    settle();
    check("t4_first_pc", iq_pc, 16'h3000);
    d_flush = 1; d_fpc = 16'h4000;
    cycle();
    d_flush = 0;
    settle();
    check("t5_addr", icache_address, 16'h4000);
    check("t5_read", icache_read, 1);
    fixed_lat = 5;
    cycle();
    d_flush = 1; d_fpc = 16'h4444;
    cycle();
    d_fpc = 16'h5000;
    cycle();
    d_flush = 0; fixed_lat = 0;
    for (int i = 0; i < 20 && m_disc; i++) cycle();
    settle();
    check("t5_post_discard", icache_address, 16'h5000);
    d_flush = 1; d_fpc = 16'hFFFE;
    cycle();
    d_flush = 0;
    cycle();
    settle();
    check("t6_wrap", icache_address, 16'h0000);
    fixed_lat = 8;
    cycle();
    cycle();
    @(negedge clk);
    icache_resp = 0; flush = 0; iq_dequeue = 0;
    #2 reset = 1;
    #1;
    check("t6_rst_read", icache_read, 0);
    check("t6_rst_empty", iq_empty, 1);
    settle();
    reset = 0;
    model_reset();
    fixed_lat = 0;
    cycle();
    settle();
    check("t6_restart", icache_address, 16'h0000);
    fixed_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      d_flush = $urandom_range(99) < 4;
      d_fpc = 16'($urandom);
      d_deq = $urandom_range(99) < ((i / 300) % 2 == 1 ? 85 : 25);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
